regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the pipelined core, successor to the single-write, two-read file.
- Configurable width, depth and read/write port counts.
- Optional hardwired-zero register and same-cycle write-to-read bypass.
- Integrated busy-bit scoreboard: decode sets a destination busy at issue; writeback clears it; read ports report pending hazards.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address width.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy.
- BYPASS, 1, 1 = a read returns same-cycle write data on address match.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_busy  out  NUM_RD  1 = addressed register has a pending writer.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
- wr_data  in  NUM_WR*DATA_W  packed write data.
- issue_en  in  1  set busy bit of issue_addr.
- issue_addr  in  ADDR_W  destination being issued.
- busy_vec  out  DEPTH  registered scoreboard bits.
- wr_conflict  out  1  registered; 1 = previous cycle had two enabled writes to the same address.

Behaviour:
- Reset: rst=1 at a clock edge clears all registers, busy_vec and wr_conflict to 0 in that cycle, regardless of other inputs. Writes and issues presented during reset are discarded.
- Reset is active-high and synchronous on clk. With no edge, asynchronous rst assertion has no effect.
- Writes:
  - Storage is updated on the rising edge when wr_en[j]=1.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Write collision:
  - Both ports enabled to the same address: the higher-index port (1) wins.
  - wr_conflict=1 in the following cycle; it is a single-cycle pulse per colliding cycle.
  - A write to address 0 with ZERO_REG=1 is not a conflict.
- Reads: combinational from rd_addr with zero cycles of latency; any number of ports may read the same address.
- Bypass:
  - With BYPASS=1, if any enabled write matches rd_addr[i] (excluding address 0 when ZERO_REG=1), rd_data[i] = that write's data.
  - The highest matching write port wins.
  - With BYPASS=0, the old stored value is returned until after the edge.
- Zero register: with ZERO_REG=1, reads of address 0 return 0 and rd_busy=0.
- Scoreboard (per address a, next state):
  - Set when issue_en && issue_addr==a.
  - Else clear when any wr_en[j] && wr_addr[j]==a.
  - Else hold.
  - Issue wins over a same-cycle writeback to the same address, since the new producer supersedes the old one.
  - issue to address 0 with ZERO_REG=1 is ignored.
- rd_busy[i] = busy_vec[rd_addr[i]], masked to 0 when BYPASS=1 and a same-cycle write matches rd_addr[i], because that value is being delivered now.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- Expected size: 150-250 lines of RTL. Generate loops are required for ports. No latches: storage lives only in a clk-edge process.

Test Plan:
1. Reset: write 0xDEADBEEF to r5, issue r7, then assert rst for 1 cycle with wr_en=1 to r5 value 0x1 -> after the edge r5 reads 0, busy_vec=0, wr_conflict=0.
2. Write/read with BYPASS=1: wr_en[0]=1, wr_addr=3, wr_data=0x12345678, rd_addr[0]=3 in the same cycle -> rd_data[0]=0x12345678 combinationally. The next cycle, with no write, it still reads 0x12345678. With BYPASS=0, the old value 0 is returned in the write cycle.
3. Zero register: write 0xFFFFFFFF to r0 and issue r0 -> rd_data reads 0, busy_vec[0]=0, rd_busy=0.
4. Scoreboard: issue r9 at cycle t -> busy_vec[9]=1 from t+1, and rd_busy=1 for a port reading r9. At cycle t+3, write r9=0xA5 with issue_en=1 to r9 -> busy stays 1 and rd_busy in that cycle is 0 via bypass. At t+5, write r9 only -> busy_vec[9]=0 at t+6.
5. Dual-write collision (NUM_WR=2): both ports write r4 with 0x11 and 0x22 -> r4=0x22 and wr_conflict=1 for exactly one cycle. With ports writing r4 and r6, both update and wr_conflict=0.
6. Multi-read: NUM_RD=4, all ports reading r4, r6, r0 and r4 -> 0x22, the r6 value, 0 and 0x22 simultaneously.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass and busy-bit scoreboard
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [DEPTH-1:0]         busy_vec,
  output logic                     wr_conflict
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [NUM_WR-1:0] w_we;
  logic              w_issue;
  logic              w_conflict;
  logic [DEPTH-1:0]  w_busy_nxt;
  for (genvar j = 0; j < NUM_WR; j++) begin : g_we
    assign w_we[j] = wr_en[j] && !(ZERO_REG == 1 && wr_addr[j*ADDR_W +: ADDR_W] == '0);
  end
  assign w_issue = issue_en && !(ZERO_REG == 1 && issue_addr == '0);
  if (NUM_WR == 2) begin : g_cf
    assign w_conflict = &w_we && wr_addr[0 +: ADDR_W] == wr_addr[ADDR_W +: ADDR_W];
  end else begin : g_nc
    assign w_conflict = 1'b0;
  end
  always_comb begin
    w_busy_nxt = busy_vec;
    for (int j = 0; j < NUM_WR; j++)
      if (w_we[j]) w_busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
    if (w_issue) w_busy_nxt[issue_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
      wr_conflict <= 1'b0;
      for (int a = 0; a < DEPTH; a++) r_mem[a] <= '0;
    end else begin
      busy_vec <= w_busy_nxt;
      wr_conflict <= w_conflict;
      for (int j = 0; j < NUM_WR; j++)
        if (w_we[j]) r_mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_hit;
    logic              w_zero;
    logic [DATA_W-1:0] w_bd;
    assign w_a = rd_addr[i*ADDR_W +: ADDR_W];
    assign w_zero = ZERO_REG == 1 && w_a == '0;
    always_comb begin
      w_hit = 1'b0;
      w_bd = '0;
      for (int j = 0; j < NUM_WR; j++)
        if (BYPASS == 1 && w_we[j] && wr_addr[j*ADDR_W +: ADDR_W] == w_a) begin
          w_hit = 1'b1;
          w_bd = wr_data[j*DATA_W +: DATA_W];
        end
    end
    assign rd_data[i*DATA_W +: DATA_W] = w_zero ? '0 : w_hit ? w_bd : r_mem[w_a];
    assign rd_busy[i] = !w_zero && !w_hit && busy_vec[w_a];
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: checks a 4R/2W bypassing file and a 2R/1W non-bypassing file against a model
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst;
  logic [1:0]  we;
  logic [4:0]  wa0, wa1, ia;
  logic [31:0] wd0, wd1;
  logic        ie;
  logic [4:0]  ra [4];
  logic [127:0] a_rd_data;
  logic [3:0]   a_rd_busy;
  logic [31:0]  a_busy;
  logic         a_conf;
  logic [63:0]  b_rd_data;
  logic [1:0]   b_rd_busy;
  logic [31:0]  b_busy;
  logic         b_conf;
  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  logic [31:0] mem [2][32];
  logic [31:0] bsy [2];
  logic        cf [2];
  regfile_mp_sb #(.NUM_RD(4), .NUM_WR(2)) u_a (
    .clk(clk), .rst(rst), .rd_addr({ra[3], ra[2], ra[1], ra[0]}), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .wr_en(we), .wr_addr({wa1, wa0}), .wr_data({wd1, wd0}),
    .issue_en(ie), .issue_addr(ia), .busy_vec(a_busy), .wr_conflict(a_conf)
  );
  regfile_mp_sb #(.NUM_RD(2), .NUM_WR(1), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_addr({ra[1], ra[0]}), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .wr_en(we[0]), .wr_addr(wa0), .wr_data(wd0),
    .issue_en(ie), .issue_addr(ia), .busy_vec(b_busy), .wr_conflict(b_conf)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] xdata(input int k, input logic [4:0] a);
    logic [31:0] d;
    if (a == 0) return 32'h0;
    d = mem[k][a];
    if (k == 0 && we[0] && wa0 == a) d = wd0;
    if (k == 0 && we[1] && wa1 == a) d = wd1;
    return d;
  endfunction
  function automatic logic xbusy(input int k, input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (k == 0 && ((we[0] && wa0 == a) || (we[1] && wa1 == a))) return 1'b0;
    return bsy[k][a];
  endfunction
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int a = 0; a < 32; a++) mem[k][a] = 32'h0;
        bsy[k] = 32'h0;
        cf[k] = 1'b0;
      end else begin
        cf[k] = k == 0 && we == 2'b11 && wa0 == wa1 && wa0 != 0;
        if (we[0] && wa0 != 0) begin
          mem[k][wa0] = wd0;
          bsy[k][wa0] = 1'b0;
        end
        if (k == 0 && we[1] && wa1 != 0) begin
          mem[k][wa1] = wd1;
          bsy[k][wa1] = 1'b0;
        end
        if (ie && ia != 0) bsy[k][ia] = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("a_rd_data[%0d]", i), a_rd_data[i*32 +: 32], xdata(0, ra[i]));
        chk($sformatf("a_rd_busy[%0d]", i), 32'(a_rd_busy[i]), 32'(xbusy(0, ra[i])));
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("b_rd_data[%0d]", i), b_rd_data[i*32 +: 32], xdata(1, ra[i]));
        chk($sformatf("b_rd_busy[%0d]", i), 32'(b_rd_busy[i]), 32'(xbusy(1, ra[i])));
      end
      chk("a_busy_vec", a_busy, bsy[0]);
      chk("b_busy_vec", b_busy, bsy[1]);
      chk("a_wr_conflict", 32'(a_conf), 32'(cf[0]));
      chk("b_wr_conflict", 32'(b_conf), 32'(cf[1]));
    end
  end
  task automatic drv(input logic r, input logic [1:0] e, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1, input logic i_e, input logic [4:0] i_a);
    rst = r;
    we = e;
    wa0 = a0;
    wd0 = d0;
    wa1 = a1;
    wd1 = d1;
    ie = i_e;
    ia = i_a;
  endtask
  task automatic idle();
    drv(0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    ra = '{default: 5'd0};
    drv(1, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    armed = 1'b1;
    drv(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 1, 7);
    tick();
    idle();
    ra[0] = 5;
    #1;
    chk("t1_write_r5", a_rd_data[31:0], 32'hDEADBEEF);
    chk("t1_issue_r7", a_busy, 32'h0000_0080);
    drv(1, 2'b01, 5, 32'h1, 0, 0, 1, 9);
    tick();
    idle();
    #1;
    chk("t1_rst_r5_a", a_rd_data[31:0], 32'h0);
    chk("t1_rst_r5_b", b_rd_data[31:0], 32'h0);
    chk("t1_rst_busy", a_busy, 32'h0);
    chk("t1_rst_conf", 32'(a_conf), 32'h0);
    ra[0] = 3;
    drv(0, 2'b01, 3, 32'h12345678, 0, 0, 0, 0);
    #1;
    chk("t2_bypass_a", a_rd_data[31:0], 32'h12345678);
    chk("t2_nobypass_b", b_rd_data[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("t2_stored_a", a_rd_data[31:0], 32'h12345678);
    chk("t2_stored_b", b_rd_data[31:0], 32'h12345678);
    ra = '{default: 5'd0};
    drv(0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0);
    #1;
    chk("t3_r0_read", a_rd_data[31:0], 32'h0);
    chk("t3_r0_busy", 32'(a_rd_busy[0]), 32'h0);
    tick();
    idle();
    #1;
    chk("t3_r0_after", a_rd_data[31:0], 32'h0);
    chk("t3_busy_vec", a_busy, 32'h0);
    drv(0, 2'b00, 0, 0, 0, 0, 1, 9);
    tick();
    idle();
    ra[1] = 9;
    #1;
    chk("t4_busy_set", a_busy, 32'h0000_0200);
    chk("t4_rd_busy", 32'(a_rd_busy[1]), 32'h1);
    tick();
    tick();
    drv(0, 2'b01, 9, 32'hA5, 0, 0, 1, 9);
    #1;
    chk("t4_bypass_unbusy_a", 32'(a_rd_busy[1]), 32'h0);
    chk("t4_busy_nobypass_b", 32'(b_rd_busy[1]), 32'h1);
    chk("t4_bypass_data", a_rd_data[63:32], 32'hA5);
    tick();
    idle();
    #1;
    chk("t4_issue_wins", a_busy, 32'h0000_0200);
    chk("t4_r9_data", a_rd_data[63:32], 32'hA5);
    tick();
    drv(0, 2'b01, 9, 32'hB6, 0, 0, 0, 0);
    tick();
    idle();
    #1;
    chk("t4_busy_clr_a", a_busy, 32'h0);
    chk("t4_busy_clr_b", b_busy, 32'h0);
    ra[0] = 4;
    drv(0, 2'b11, 4, 32'h11, 4, 32'h22, 0, 0);
    #1;
    chk("t5_bypass_prio", a_rd_data[31:0], 32'h22);
    tick();
    idle();
    #1;
    chk("t5_r4_a", a_rd_data[31:0], 32'h22);
    chk("t5_r4_b", b_rd_data[31:0], 32'h11);
    chk("t5_conf_pulse", 32'(a_conf), 32'h1);
    tick();
    chk("t5_conf_drop", 32'(a_conf), 32'h0);
    drv(0, 2'b11, 4, 32'h22, 6, 32'h66, 0, 0);
    tick();
    idle();
    ra[1] = 6;
    #1;
    chk("t5_no_conf", 32'(a_conf), 32'h0);
    chk("t5_r6", a_rd_data[63:32], 32'h66);
    drv(0, 2'b11, 0, 32'h5, 0, 32'h7, 0, 0);
    tick();
    idle();
    #1;
    chk("t5_r0_no_conf", 32'(a_conf), 32'h0);
    ra = '{5'd4, 5'd6, 5'd0, 5'd4};
    #1;
    chk("t6_p0", a_rd_data[31:0], 32'h22);
    chk("t6_p1", a_rd_data[63:32], 32'h66);
    chk("t6_p2", a_rd_data[95:64], 32'h0);
    chk("t6_p3", a_rd_data[127:96], 32'h22);
    for (int n = 0; n < 80; n++) begin
      drv($urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
      for (int i = 0; i < 4; i++) ra[i] = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
